// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package rr_arbiter_4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int         N_REQ   = 4;
    localparam logic [1:0] PTR_RST = 2'b11;

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 binary-to-one-hot decoder used to drive the grant select.
module Decoder_2to4 (
    input  logic [1:0] A,
    output logic [3:0] Y
);

    assign Y = 4'b0001 << A;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with bounded hold time
// and one idle cycle between consecutive grants.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_ptr;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_timeout;
    logic [2:0]    w_pick;
    logic [3:0]    w_dec;

    // Nearest set bit after ptr wins; ptr itself has lowest priority.
    function automatic logic [2:0] rr_pick(
        input logic [1:0] ptr,
        input logic [3:0] rq
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (rq[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_pick = rr_pick(r_ptr, req);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick[2]) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_pick[1:0];
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (done || !req[r_idx]) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= PTR_RST;
            r_idx   <= PTR_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == IDLE && w_pick[2]) r_ptr <= w_pick[1:0];
        end
    end

    Decoder_2to4 u_dec (
        .A (r_idx),
        .Y (w_dec)
    );

    assign busy    = (r_state == GRANT);
    assign gnt     = w_dec & {4{busy}};
    assign gnt_idx = r_idx;
    assign timeout = w_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomized and directed bench for rr_arbiter_4 against a reference model.
module tb_rr_arbiter_4;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int n_chk;
    int n_fail;

    // reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_held;

    rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_idx  = 3;
        m_ptr  = 3;
        m_held = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"}, int'(busy), int'(m_busy));
        chk({tag, ".gnt"}, int'(gnt), m_busy ? (1 << m_idx) : 0);
        chk({tag, ".idx"}, int'(gnt_idx), m_idx);
    endtask

    // Drive one cycle of inputs, check timeout before the edge,
    // advance the model at the edge and check registered outputs.
    task automatic step(input logic [3:0] r, input logic d);
        bit exp_to;
        bit found;
        req  = r;
        done = d;
        #1;
        exp_to = m_busy && !d && r[m_idx] && (m_held == MH);
        chk("timeout", int'(timeout), int'(exp_to));
        @(posedge clk);
        if (m_busy) begin
            if (d || !r[m_idx] || m_held == MH) m_busy = 0;
            else m_held++;
        end else if (r != 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found  = 1;
                    m_idx  = (m_ptr + k) % 4;
                    m_ptr  = m_idx;
                    m_busy = 1;
                    m_held = 1;
                end
            end
        end
        #1;
        check_outputs("step");
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.gnt", int'(gnt), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.timeout", int'(timeout), 0);
        chk("rst.idx", int'(gnt_idx), 3);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        int to_cycles;
        logic [3:0] r;
        logic d;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        model_reset();
        #2;
        do_reset();

        // single requester
        step(4'b0100, 1'b0);
        chk("single.gnt", int'(gnt), 4'b0100);
        chk("single.idx", int'(gnt_idx), 2);
        step(4'b0100, 1'b1);
        chk("single.rel", int'(gnt), 0);

        // fairness with done every grant
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0);
            chk("fair.idx", int'(gnt_idx), i % 4);
            step(4'b1111, 1'b1);
            chk("fair.idle", int'(busy), 0);
        end

        // forced release after MH cycles
        do_reset();
        busy_cycles = 0;
        to_cycles   = 0;
        step(4'b0010, 1'b0);
        for (int i = 0; i < MH; i++) begin
            busy_cycles += int'(busy);
            req = 4'b0010;
            #1;
            to_cycles += int'(timeout);
            if (i == MH - 1) chk("to.last", int'(timeout), 1);
            step(4'b0010, 1'b0);
        end
        chk("to.busy_cycles", busy_cycles, MH);
        chk("to.pulses", to_cycles, 1);
        chk("to.idle", int'(busy), 0);
        step(4'b0010, 1'b0);
        chk("to.regrant", int'(gnt), 4'b0010);

        // withdrawal and masking
        do_reset();
        step(4'b1000, 1'b0);
        chk("wd.gnt3", int'(gnt), 4'b1000);
        step(4'b1001, 1'b0);
        chk("mask.hold3", int'(gnt), 4'b1000);
        step(4'b0001, 1'b0);
        chk("wd.rel", int'(busy), 0);
        step(4'b0001, 1'b0);
        chk("wd.gnt0", int'(gnt), 4'b0001);

        // asynchronous reset mid-grant
        do_reset();
        step(4'b1000, 1'b0);
        req = 4'b1001;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("amr.gnt", int'(gnt), 0);
        chk("amr.busy", int'(busy), 0);
        chk("amr.idx", int'(gnt_idx), 3);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(4'b1001, 1'b0);
        chk("amr.first0", int'(gnt), 4'b0001);

        // done in IDLE, done coincident with timeout
        do_reset();
        step(4'b0000, 1'b1);
        chk("idle_done.busy", int'(busy), 0);
        step(4'b0100, 1'b0);
        for (int i = 0; i < MH - 1; i++) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        chk("done_to.rel", int'(busy), 0);

        // random traffic
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            step(r, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
